// File: rtl/rip_ro_sampler_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rip_ro_sampler_ctrl
//  Description : Ring-oscillator sampling sequencer. Enables one oscillator
//                at a time, waits a programmable settle time, counts
//                synchronized rising edges over a programmable window and
//                returns the count through a valid/ready result port.
//                Runs a single oscillator or scans sel_idx..NUM_RO-1.
//  Ports       : clk, rst             - clock, async active-high reset
//                start, scan, sel_idx - run request and run mode / index
//                cfg_settle           - settle cycles after enable
//                cfg_window           - count window length (0 acts as 1)
//                ro_in                - raw oscillator outputs (async)
//                ro_rstn              - per-oscillator enable (1 = running)
//                busy                 - sequencer not idle
//                res_valid/res_ready  - result handshake
//                res_data, res_idx    - edge count and its oscillator
//                done                 - one-cycle end-of-sequence pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module rip_ro_sampler_ctrl #(
    parameter  int NUM_RO = 4,
    parameter  int CNT_W  = 16,
    parameter  int WIN_W  = 16,
    localparam int IW     = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              scan,
    input  logic [IW-1:0]     sel_idx,
    input  logic [WIN_W-1:0]  cfg_settle,
    input  logic [WIN_W-1:0]  cfg_window,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_rstn,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_data,
    output logic [IW-1:0]     res_idx,
    output logic              done
);

    localparam logic [1:0]    c_st_idle   = 2'd0;
    localparam logic [1:0]    c_st_settle = 2'd1;
    localparam logic [1:0]    c_st_count  = 2'd2;
    localparam logic [1:0]    c_st_report = 2'd3;
    localparam int            c_idx_span  = 2 ** IW;
    localparam logic [IW-1:0] c_last      = IW'(NUM_RO - 1);

    logic [1:0]            r_state;
    logic [NUM_RO-1:0]     r_sync1;
    logic [NUM_RO-1:0]     r_sync2;
    logic                  r_prev;
    logic                  r_scan;
    logic [IW-1:0]         r_idx;
    logic [WIN_W-1:0]      r_settle_cfg;
    logic [WIN_W-1:0]      r_win_cfg;
    logic [WIN_W-1:0]      r_settle_cnt;
    logic [WIN_W-1:0]      r_win_cnt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_done;

    // Index-space padded views so any IW-bit index selects a defined bit,
    // even when NUM_RO is not a power of two.
    logic [c_idx_span-1:0] w_sync_pad;
    logic [c_idx_span-1:0] w_idx_ok;
    logic                  w_sel_ok;
    logic                  w_edge;
    logic                  w_run;

    for (genvar gi = 0; gi < c_idx_span; gi++) begin : g_pad
        if (gi < NUM_RO) begin : g_real
            assign w_sync_pad[gi] = r_sync2[gi];
            assign w_idx_ok[gi]   = 1'b1;
        end else begin : g_unused
            assign w_sync_pad[gi] = 1'b0;
            assign w_idx_ok[gi]   = 1'b0;
        end
    end

    assign w_sel_ok = w_idx_ok[sel_idx];
    assign w_edge   = w_sync_pad[r_idx] & ~r_prev;
    assign w_run    = (r_state == c_st_settle) || (r_state == c_st_count);

    // Enable is decoded from registered state only, so it is one-hot or zero
    // and drops in the same cycle as an asynchronous reset.
    for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_rstn
        assign ro_rstn[gi] = w_run && (r_idx == IW'(gi));
    end

    assign busy      = (r_state != c_st_idle);
    assign res_valid = (r_state == c_st_report);
    assign res_data  = r_cnt;
    assign res_idx   = r_idx;
    assign done      = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_prev       <= 1'b0;
            r_scan       <= 1'b0;
            r_idx        <= '0;
            r_settle_cfg <= '0;
            r_win_cfg    <= '0;
            r_settle_cnt <= '0;
            r_win_cnt    <= '0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
            r_done  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start && w_sel_ok) begin
                        r_scan       <= scan;
                        r_idx        <= sel_idx;
                        r_settle_cfg <= cfg_settle;
                        r_win_cfg    <= (cfg_window == '0) ? WIN_W'(1) : cfg_window;
                        r_settle_cnt <= cfg_settle;
                        r_state      <= c_st_settle;
                    end
                end
                c_st_settle: begin
                    r_prev <= w_sync_pad[r_idx];
                    if (r_settle_cnt == '0) begin
                        r_cnt     <= '0;
                        r_win_cnt <= r_win_cfg;
                        r_state   <= c_st_count;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - WIN_W'(1);
                    end
                end
                c_st_count: begin
                    r_prev <= w_sync_pad[r_idx];
                    if (w_edge && (r_cnt != {CNT_W{1'b1}})) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (r_win_cnt == WIN_W'(1)) begin
                        r_state <= c_st_report;
                    end else begin
                        r_win_cnt <= r_win_cnt - WIN_W'(1);
                    end
                end
                default: begin
                    if (res_ready) begin
                        if (r_scan && (r_idx != c_last)) begin
                            r_idx        <= r_idx + IW'(1);
                            r_settle_cnt <= r_settle_cfg;
                            r_state      <= c_st_settle;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= c_st_idle;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rip_ro_sampler_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rip_ro_sampler_ctrl
//  Description : Directed, table-driven bench for rip_ro_sampler_ctrl plus a
//                second instance (NUM_RO=3, CNT_W=4) for saturation and
//                out-of-range index behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rip_ro_sampler_ctrl;

    localparam int LIM = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sat_start;
    logic        scan;
    logic [1:0]  sel_idx;
    logic [15:0] cfg_settle;
    logic [15:0] cfg_window;
    logic [3:0]  ro_in;
    logic [3:0]  ro_rstn;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_idx;
    logic        done;

    logic [2:0]  sat_rstn;
    logic        sat_busy;
    logic        sat_valid;
    logic [3:0]  sat_data;
    logic [1:0]  sat_idx;
    logic        sat_done;

    int checks = 0;
    int errors = 0;
    int half[4] = '{1, 1, 1, 1};
    int cyc = 0;
    int bad_rstn;

    rip_ro_sampler_ctrl #(.NUM_RO(4), .CNT_W(16), .WIN_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .scan(scan), .sel_idx(sel_idx),
        .cfg_settle(cfg_settle), .cfg_window(cfg_window), .ro_in(ro_in),
        .ro_rstn(ro_rstn), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
        .done(done)
    );

    rip_ro_sampler_ctrl #(.NUM_RO(3), .CNT_W(4), .WIN_W(16)) u_sat (
        .clk(clk), .rst(rst), .start(sat_start), .scan(scan), .sel_idx(sel_idx),
        .cfg_settle(cfg_settle), .cfg_window(cfg_window), .ro_in(ro_in[2:0]),
        .ro_rstn(sat_rstn), .busy(sat_busy), .res_valid(sat_valid),
        .res_ready(1'b1), .res_data(sat_data), .res_idx(sat_idx),
        .done(sat_done)
    );

    always #5 clk = ~clk;

    // Oscillator model: bit i toggles every half[i] clk cycles (0 = static low).
    initial begin
        ro_in = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 4; i++)
                ro_in[i] = (half[i] == 0) ? 1'b0 : (((cyc / half[i]) % 2) == 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] sel;
        int         settle;
        int         window;
        int         hp;
        int         lat;
        int         lo;
        int         hi;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic start_meas(input logic s, input logic [1:0] sel, input int st, input int w);
        scan       = s;
        sel_idx    = sel;
        cfg_settle = st[15:0];
        cfg_window = w[15:0];
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Waits for res_valid; lat is the cycle number (start cycle = 0).
    // Also checks ro_rstn: exactly the expected one-hot on the first cycle,
    // never anything but that one-hot or zero afterwards.
    task automatic wait_valid(input logic [1:0] idx, input logic poke, output int lat);
        logic [3:0] oh;
        oh  = 4'b0001 << idx;
        lat = 1;
        while (!res_valid && lat < LIM) begin
            if (lat == 1 && ro_rstn != oh) bad_rstn++;
            if (ro_rstn != 4'b0000 && ro_rstn != oh) bad_rstn++;
            start = poke && (lat == 2 || lat == 10);
            tick();
            lat++;
        end
        start = 1'b0;
        chk("valid_seen", res_valid, 1);
    endtask

    task automatic collect(input logic [1:0] idx, input int lo, input int hi,
                           input int stall, input logic last);
        logic [15:0] d0;
        int          bad;
        d0  = res_data;
        bad = 0;
        chk("res_idx", res_idx, idx);
        chk_rng("res_data", res_data, lo, hi);
        chk("rstn_in_report", ro_rstn, 0);
        res_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (res_data != d0 || !res_valid || ro_rstn != 4'b0000 || res_idx != idx || done)
                bad++;
        end
        if (stall > 0) chk("stall_stable", bad, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("valid_drop", res_valid, 0);
        chk("done", done, last);
        chk("busy_after", busy, !last);
        if (last) begin
            tick();
            chk("done_pulse_end", done, 0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        for (int i = 0; i < 4; i++) half[i] = 1;
        half[v.sel] = v.hp;
        repeat (4) tick();
        bad_rstn = 0;
        start_meas(1'b0, v.sel, v.settle, v.window);
        wait_valid(v.sel, 1'b0, lat);
        chk("latency", lat, v.lat);
        chk("ro_rstn_run", bad_rstn, 0);
        collect(v.sel, v.lo, v.hi, 2, 1'b1);
    endtask

    initial begin
        int lat;
        int bad;

        //            sel    S  W    hp lat  lo hi
        vecs[0] = '{2'd2,  3, 100, 5, 105, 9, 11};
        vecs[1] = '{2'd0,  0, 20,  2, 22,  4, 6};
        vecs[2] = '{2'd3,  5, 0,   1, 8,   0, 1};
        vecs[3] = '{2'd1,  0, 0,   0, 3,   0, 0};
        vecs[4] = '{2'd3,  2, 50,  0, 54,  0, 0};

        rst = 1'b1; start = 1'b0; sat_start = 1'b0; scan = 1'b0; sel_idx = '0;
        cfg_settle = '0; cfg_window = '0; res_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset / idle, with res_ready alone having no effect
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_rstn", ro_rstn, 0);
        chk("rst_data", res_data, 0);
        chk("rst_idx", res_idx, 0);
        res_ready = 1'b1;
        bad = 0;
        repeat (6) begin
            tick();
            if (busy || res_valid || done || ro_rstn != 4'b0000 || sat_busy || sat_rstn != 3'b000) bad++;
        end
        res_ready = 1'b0;
        chk("idle_quiet", bad, 0);

        // Single measurements from the vector table
        foreach (vecs[k]) run_vec(vecs[k]);

        // Scan 1..3 with 20-cycle backpressure per result
        half[0] = 1; half[1] = 1; half[2] = 3; half[3] = 0;
        repeat (4) tick();
        bad_rstn = 0;
        start_meas(1'b1, 2'd1, 2, 30);
        wait_valid(2'd1, 1'b0, lat);
        chk("scan_lat1", lat, 34);
        collect(2'd1, 14, 16, 20, 1'b0);
        wait_valid(2'd2, 1'b0, lat);
        chk("scan_lat2", lat, 34);
        collect(2'd2, 4, 6, 20, 1'b0);
        wait_valid(2'd3, 1'b0, lat);
        chk("scan_lat3", lat, 34);
        collect(2'd3, 0, 0, 20, 1'b1);
        chk("scan_rstn", bad_rstn, 0);

        // Start pulses while busy are ignored; latched config unchanged
        half[0] = 1; half[1] = 1; half[2] = 2; half[3] = 1;
        repeat (4) tick();
        bad_rstn = 0;
        start_meas(1'b0, 2'd2, 3, 40);
        scan = 1'b1; sel_idx = 2'd0; cfg_settle = 16'd0; cfg_window = 16'd2;
        wait_valid(2'd2, 1'b1, lat);
        chk("busy_start_lat", lat, 45);
        chk("busy_start_rstn", bad_rstn, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("report_start_valid", res_valid, 1);
        collect(2'd2, 9, 11, 0, 1'b1);

        // Saturation (CNT_W=4, ~50 edges) on the second instance
        for (int i = 0; i < 4; i++) half[i] = 1;
        scan = 1'b0; sel_idx = 2'd0; cfg_settle = 16'd1; cfg_window = 16'd100;
        repeat (4) tick();
        sat_start = 1'b1;
        tick();
        sat_start = 1'b0;
        lat = 1;
        while (!sat_valid && lat < LIM) begin
            tick();
            lat++;
        end
        chk("sat_valid_seen", sat_valid, 1);
        chk("sat_lat", lat, 103);
        chk("sat_data", sat_data, 15);
        chk("sat_idx", sat_idx, 0);
        tick();
        chk("sat_done", sat_done, 1);

        // Out-of-range index on the NUM_RO=3 instance: start ignored
        sel_idx = 2'd3;
        sat_start = 1'b1;
        tick();
        sat_start = 1'b0;
        bad = 0;
        repeat (5) begin
            if (sat_busy || sat_rstn != 3'b000 || sat_valid) bad++;
            tick();
        end
        chk("bad_sel_idle", bad, 0);

        // Asynchronous reset in the middle of COUNT
        half[1] = 2;
        repeat (4) tick();
        start_meas(1'b0, 2'd1, 2, 60);
        repeat (20) tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_rstn", ro_rstn, 4'b0010);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rstn", ro_rstn, 0);
        chk("arst_idx", res_idx, 0);
        chk("arst_data", res_data, 0);
        tick();
        rst = 1'b0;
        bad = 0;
        repeat (80) begin
            if (res_valid || busy || done) bad++;
            tick();
        end
        chk("arst_no_result", bad, 0);
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rip_ro_sampler_ctrl.md
Name: rip_ro_sampler_ctrl

Overview:
- Sequencer for a bank of NUM_RO ring oscillators in the reservoir datapath.
- Enables one oscillator at a time by driving that oscillator's active-low reset/enable line, and waits a programmable settle time.
- Counts synchronized rising edges of the oscillator over a programmable window of clk cycles, then returns the count through a valid/ready result port.
- Runs either a single selected oscillator or a scan from the selected index up to the last oscillator.

Parameters:
- NUM_RO, 4, number of oscillators controlled (1..16).
- CNT_W, 16, width of the edge counter and result data.
- WIN_W, 16, width of the window and settle configuration fields.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- scan  input  1  0 = measure sel_idx only; 1 = measure sel_idx..NUM_RO-1 in order. Sampled with start.
- sel_idx  input  $clog2(NUM_RO) (min 1)  first/only oscillator index. Sampled with start.
- cfg_settle  input  WIN_W  settle cycles after enable. Sampled with start.
- cfg_window  input  WIN_W  count-window length in cycles. Sampled with start.
- ro_in  input  NUM_RO  raw oscillator outputs, asynchronous to clk.
- ro_rstn  output  NUM_RO  per-oscillator enable; 1 = running, 0 = held.
- busy  output  1  high in every state except IDLE.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  CNT_W  edge count.
- res_idx  output  $clog2(NUM_RO) (min 1)  oscillator the result belongs to.
- done  output  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (async, rst=1): state=IDLE; ro_rstn=0, busy=0, res_valid=0, res_data=0, res_idx=0, done=0; synchronizers and counters cleared. Assertion mid-operation aborts immediately; no result is emitted.
- Synchronizer: each ro_in bit passes through 2 flops, always clocked. edge = sync2[idx] & ~prev, where prev is sync2[idx] delayed by one cycle. prev is updated in SETTLE and COUNT.
- IDLE:
  - On start=1: latch scan, sel_idx→idx, cfg_settle, and cfg_window (a latched window of 0 is replaced by 1).
  - Next cycle state=SETTLE with settle counter = latched settle.
  - sel_idx >= NUM_RO: start is ignored and the block stays idle.
  - start outside IDLE is ignored.
- SETTLE:
  - ro_rstn[idx]=1; all other bits 0.
  - Each cycle: if the counter is 0, go to COUNT; otherwise decrement.
  - Settle=0 therefore spends exactly 1 cycle in SETTLE.
  - Edges are not counted in SETTLE.
- COUNT:
  - ro_rstn[idx] stays 1. Edge count is cleared on entry.
  - Lasts exactly the latched window cycles. Each of these cycles adds edge to the count.
  - Count saturates at 2^CNT_W-1 and does not wrap.
  - After the last window cycle: state=REPORT.
- REPORT:
  - ro_rstn all 0. res_valid=1; res_data=count and res_idx=idx, both stable while res_valid=1.
  - Handshake completes in a cycle with res_valid&res_ready. res_ready alone does nothing.
  - On handshake:
    - If scan=1 and idx<NUM_RO-1: idx+1, state=SETTLE, settle counter reloaded.
    - Otherwise: state=IDLE, done=1 for the next cycle only.
- ro_rstn is one-hot or zero at all times; it is never multi-hot.
- Result latency for settle=S, window=W: res_valid rises S+W+2 cycles after the start cycle.

Test Plan:
- Reset/idle: rst pulse, no start → all outputs 0; busy=0; ro_rstn=0 throughout.
- Single measure: ro_in[2] toggles with period 10 clk; start, scan=0, sel_idx=2, settle=3, window=100 → ro_rstn=4'b0100 only; res_valid at cycle 105; res_data=10±1; res_idx=2; done one cycle after handshake.
- Scan with backpressure: scan=1, sel_idx=1, NUM_RO=4, res_ready low for 20 cycles per result → results idx 1,2,3 in order; data stable while stalled; ro_rstn=0 during REPORT; one done pulse.
- Boundaries: window=0 → 1-cycle count, res_data ≤1. Settle=0 → COUNT follows 1 SETTLE cycle. CNT_W=4 with 50 edges → res_data=15 (saturated). sel_idx=NUM_RO → busy stays 0.
- Start while busy: extra start pulses in SETTLE/COUNT/REPORT → ignored; latched config unchanged.
- Async reset mid-COUNT: rst asserted → outputs 0 in the same cycle; no res_valid; the next start runs normally.
